// File: rtl/serial_pkg.sv
// Shared serial-link encodings: parity mode (common with the transmitter) and RX FSM states.
package serial_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_ODD  = 2'b01,
      PAR_EVEN = 2'b10
   } parity_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'b00,
      ST_RECV_BYTE   = 2'b01,
      ST_RECV_PARITY = 2'b10,
      ST_DONE        = 2'b11
   } rx_state_t;

endpackage

// File: rtl/serial_rx.sv
// Serial byte receiver: LSB-first, one bit per clock, optional odd/even parity bit.
// Define SERIAL_RX_ERR_CNT_EN to build the saturating parity-error counter on ERR_CNT.
module serial_rx
   import serial_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 RXD,
   input  logic                 RX_START,
   input  logic [1:0]           PARITY_MODE,
   output logic [7:0]           DATA_OUT,
   output logic                 DATA_VALID,
   output logic                 PARITY_ERR,
   output logic                 OVERRUN,
   output logic                 BUSY,
   output logic [ERR_CNT_W-1:0] ERR_CNT
);

   rx_state_t   state;
   rx_state_t   state_nxt;
   logic [2:0]  count;
   logic [1:0]  mode;
   logic [7:0]  shift;
   logic        par_bit;
   logic        start_cap;
   logic        bit_cap;
   logic        par_cap;
   logic        frame_done;
   logic        rejected;
   logic        frame_err;

   function automatic logic has_parity(input logic [1:0] m);
      return (m == PAR_ODD) || (m == PAR_EVEN);
   endfunction

   function automatic logic parity_mismatch(input logic [1:0] m, input logic [7:0] b,
                                            input logic p);
      case (m)
         PAR_ODD:  return p != ~^b;
         PAR_EVEN: return p != ^b;
         default:  return 1'b0;
      endcase
   endfunction

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:        if (RX_START) state_nxt = ST_RECV_BYTE;
         ST_RECV_BYTE:   if (count == 3'd7)
                            state_nxt = has_parity(mode) ? ST_RECV_PARITY : ST_DONE;
         ST_RECV_PARITY: state_nxt = ST_DONE;
         ST_DONE:        state_nxt = ST_IDLE;
         default:        state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      start_cap  = (state == ST_IDLE) && RX_START;
      bit_cap    = (state == ST_RECV_BYTE);
      par_cap    = (state == ST_RECV_PARITY);
      frame_done = (state == ST_DONE);
      rejected   = (state != ST_IDLE) && RX_START;
      BUSY       = (state != ST_IDLE);
   end

   assign frame_err = parity_mismatch(mode, shift, par_bit);

   // Control and visible outputs; mode is latched at frame start so mid-frame changes are ignored.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count      <= 3'd0;
         mode       <= PAR_NONE;
         DATA_OUT   <= 8'h00;
         DATA_VALID <= 1'b0;
         PARITY_ERR <= 1'b0;
         OVERRUN    <= 1'b0;
      end else begin
         DATA_VALID <= frame_done;
         OVERRUN    <= rejected;
         if (start_cap) begin
            count <= 3'd1;
            mode  <= PARITY_MODE;
         end else if (bit_cap) begin
            count <= count + 3'd1;
         end
         if (frame_done) begin
            DATA_OUT   <= shift;
            PARITY_ERR <= frame_err;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (start_cap) shift[0]     <= RXD;
      if (bit_cap)   shift[count] <= RXD;
      if (par_cap)   par_bit      <= RXD;
   end

`ifdef SERIAL_RX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         err_cnt <= '0;
      else if (frame_done && frame_err && (err_cnt != '1))
         err_cnt <= err_cnt + ERR_CNT_W'(1);
   end

   assign ERR_CNT = err_cnt;
`else
   assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: vector table of frames plus overrun, mid-frame reset and counter saturation.
module tb_serial_rx;

   localparam int ERR_CNT_W = 8;
   localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef SERIAL_RX_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic                 CLK = 1'b0;
   logic                 RST_N;
   logic                 RXD;
   logic                 RX_START;
   logic [1:0]           PARITY_MODE;
   logic [7:0]           DATA_OUT;
   logic                 DATA_VALID;
   logic                 PARITY_ERR;
   logic                 OVERRUN;
   logic                 BUSY;
   logic [ERR_CNT_W-1:0] ERR_CNT;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   typedef struct {
      logic [7:0] b;
      logic [1:0] m;
      logic       p;
      logic       err;
      string      name;
   } vec_t;

   vec_t vecs[8];

   always #5 CLK = ~CLK;

   serial_rx #(.ERR_CNT_W(ERR_CNT_W)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .RXD        (RXD),
      .RX_START   (RX_START),
      .PARITY_MODE(PARITY_MODE),
      .DATA_OUT   (DATA_OUT),
      .DATA_VALID (DATA_VALID),
      .PARITY_ERR (PARITY_ERR),
      .OVERRUN    (OVERRUN),
      .BUSY       (BUSY),
      .ERR_CNT    (ERR_CNT)
   );

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Cycle 0 carries RX_START and bit 0; cycle k carries bit k, cycle 8 the parity bit.
   // DATA_VALID is expected in cycle 9 (no parity) or 10 (parity) and nowhere else.
   task automatic frame(input logic [7:0] b, input logic [1:0] m, input logic p,
                        input logic exp_err, input int ovr_at, input string name);
      logic       has_par;
      logic [1:0] alt;
      logic [2:0] idx;
      int         lat;
      has_par = (m == 2'b01) || (m == 2'b10);
      lat     = has_par ? 10 : 9;
      alt     = (m == 2'b01) ? 2'b10 : 2'b01;
      RXD         = b[0];
      RX_START    = 1'b1;
      PARITY_MODE = m;
      for (int k = 1; k <= lat + 1; k++) begin
         tick();
         idx         = k[2:0];
         RX_START    = (k == ovr_at);
         PARITY_MODE = alt;
         RXD         = (k < 8) ? b[idx] : ((k == 8) ? p : 1'b0);
         check_bit({name, "_valid"}, DATA_VALID, k == lat);
         check_bit({name, "_busy"}, BUSY, k < lat);
         check_bit({name, "_overrun"}, OVERRUN, (ovr_at > 0) && (k == ovr_at + 1));
         if (k == lat) begin
            if (CNT_EN && exp_err && exp_cnt < CNT_MAX) exp_cnt++;
            check_val({name, "_data"}, 32'(DATA_OUT), 32'(b));
            check_bit({name, "_perr"}, PARITY_ERR, exp_err);
            check_val({name, "_errcnt"}, 32'(ERR_CNT), 32'(exp_cnt));
         end
         if (k == lat + 1) begin
            check_val({name, "_hold_data"}, 32'(DATA_OUT), 32'(b));
            check_bit({name, "_hold_perr"}, PARITY_ERR, exp_err);
         end
      end
      RXD = 1'b0;
   endtask

   initial begin
      logic [7:0] rb;
      logic [2:0] idx;

      vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, "none_a5"};
      vecs[1] = '{8'hA5, 2'b01, 1'b1, 1'b0, "odd_a5_ok"};
      vecs[2] = '{8'hA5, 2'b01, 1'b0, 1'b1, "odd_a5_err"};
      vecs[3] = '{8'h07, 2'b10, 1'b1, 1'b0, "even_07_ok"};
      vecs[4] = '{8'h07, 2'b10, 1'b0, 1'b1, "even_07_err"};
      vecs[5] = '{8'h3C, 2'b11, 1'b1, 1'b0, "mode11_3c"};
      vecs[6] = '{8'hFF, 2'b01, 1'b0, 1'b1, "odd_ff_err"};
      vecs[7] = '{8'h00, 2'b10, 1'b0, 1'b0, "even_00_ok"};

      RST_N       = 1'b0;
      RXD         = 1'b0;
      RX_START    = 1'b0;
      PARITY_MODE = 2'b00;
      tick();
      tick();
      check_val("rst_data", 32'(DATA_OUT), 32'h0);
      check_bit("rst_valid", DATA_VALID, 1'b0);
      check_bit("rst_perr", PARITY_ERR, 1'b0);
      check_bit("rst_overrun", OVERRUN, 1'b0);
      check_bit("rst_busy", BUSY, 1'b0);
      check_val("rst_errcnt", 32'(ERR_CNT), 32'h0);
      RST_N = 1'b1;
      tick();

      for (int i = 0; i < 8; i++)
         frame(vecs[i].b, vecs[i].m, vecs[i].p, vecs[i].err, -1, vecs[i].name);

      // Second RX_START during bit 4 must be rejected without disturbing the frame.
      frame(8'hC3, 2'b01, 1'b1, 1'b0, 4, "overrun_c3");

      // Reset asserted during bit 5 drops the frame and clears outputs.
      rb          = 8'h5A;
      RXD         = rb[0];
      RX_START    = 1'b1;
      PARITY_MODE = 2'b00;
      for (int k = 1; k <= 5; k++) begin
         tick();
         idx      = k[2:0];
         RX_START = 1'b0;
         RXD      = rb[idx];
      end
      #2;
      RST_N   = 1'b0;
      exp_cnt = 0;
      #1;
      check_val("midrst_data", 32'(DATA_OUT), 32'h0);
      check_bit("midrst_valid", DATA_VALID, 1'b0);
      check_bit("midrst_perr", PARITY_ERR, 1'b0);
      check_bit("midrst_overrun", OVERRUN, 1'b0);
      check_bit("midrst_busy", BUSY, 1'b0);
      check_val("midrst_errcnt", 32'(ERR_CNT), 32'h0);
      tick();
      RST_N = 1'b1;
      for (int k = 6; k < 18; k++) begin
         idx = k[2:0];
         RXD = (k < 8) ? rb[idx] : 1'b0;
         tick();
         check_bit("midrst_no_valid", DATA_VALID, 1'b0);
         check_bit("midrst_idle", BUSY, 1'b0);
      end
      frame(8'h3C, 2'b00, 1'b0, 1'b0, -1, "after_rst_3c");

      // Long run of bad-parity frames drives the counter into saturation.
      for (int i = 0; i < 300; i++)
         frame(8'hA5, 2'b01, 1'b0, 1'b1, -1, "sat");
      check_val("errcnt_final", 32'(ERR_CNT), CNT_EN ? 32'(CNT_MAX) : 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of the parity-error counter.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port RXD  input  1  serial data, one bit per CLK, LSB first, idle low.
REQ-005 SHALL have port RX_START  input  1  frame strobe, high in the cycle RXD carries data bit 0.
REQ-006 SHALL have port PARITY_MODE  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-007 SHALL have port DATA_OUT  output  8  last received byte.
REQ-008 SHALL have port DATA_VALID  output  1  one-cycle pulse, DATA_OUT/PARITY_ERR valid.
REQ-009 SHALL have port PARITY_ERR  output  1  parity mismatch for the frame, qualified by DATA_VALID.
REQ-010 SHALL have port OVERRUN  output  1  one-cycle pulse, RX_START rejected.
REQ-011 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-012 SHALL have port ERR_CNT  output  ERR_CNT_W  saturating parity-error count.

Function
REQ-013 SHALL implement states IDLE, RECV_BYTE, RECV_PARITY, DONE.
REQ-014 IDLE with RX_START=1 SHALL capture RXD into bit 0, latch PARITY_MODE, set bit count to 1, and go to RECV_BYTE.
REQ-015 RECV_BYTE SHALL capture RXD into bit[count] each cycle, with count incrementing by 1.
REQ-016 After capturing bit 7, RECV_BYTE SHALL go to RECV_PARITY if the latched mode is 01/10, else to DONE.
REQ-017 RECV_PARITY SHALL sample RXD as the parity bit and go to DONE.
REQ-018 Expected parity SHALL be ~^byte for mode 01 and ^byte for mode 10.
REQ-019 PARITY_ERR SHALL be 1 iff the mode has parity and the sampled bit differs from the expected bit, else 0.
REQ-020 DONE SHALL assert DATA_VALID for exactly one cycle, update DATA_OUT and PARITY_ERR in that cycle, then go to IDLE.
REQ-021 Latency: DATA_VALID SHALL be high 9 cycles after the RX_START edge without parity, 10 cycles with parity.
REQ-022 DATA_OUT and PARITY_ERR SHALL hold their values until the next DATA_VALID.
REQ-023 RX_START in any non-IDLE state SHALL be ignored, pulse OVERRUN one cycle, and leave the frame in progress intact.
REQ-024 PARITY_MODE changes mid-frame SHALL have no effect on that frame.

Reset
REQ-025 RST_N low SHALL immediately force state IDLE and count 0, and clear DATA_OUT, DATA_VALID, PARITY_ERR, OVERRUN and ERR_CNT.
REQ-026 Reset mid-frame SHALL discard the partial frame and produce no DATA_VALID.

Configuration
REQ-027 With SERIAL_RX_ERR_CNT_EN defined, ERR_CNT SHALL increment on each DATA_VALID with PARITY_ERR=1 and saturate at all-ones.
REQ-028 Without SERIAL_RX_ERR_CNT_EN, ERR_CNT SHALL be tied to 0 and no counter logic synthesized.

Structure
REQ-029 Package serial_pkg SHALL hold the parity-mode enum (PAR_NONE=00, PAR_ODD=01, PAR_EVEN=10) and the RX state enum; the mode encoding SHALL be shared with the transmitter.
REQ-030 No sub-module SHALL be used; parity is a single reduction in serial_rx.

Verification
REQ-031 Mode 00, RX_START with bits of 8'hA5 LSB first -> DATA_VALID at +9, DATA_OUT=8'hA5, PARITY_ERR=0.
REQ-032 Mode 01, byte 8'hA5, parity bit 1 -> DATA_VALID at +10, PARITY_ERR=0; repeat with parity bit 0 -> PARITY_ERR=1, ERR_CNT=1 (macro on).
REQ-033 Mode 10, byte 8'h07, parity bit 1 -> PARITY_ERR=0; parity bit 0 -> PARITY_ERR=1.
REQ-034 RX_START again at bit 4 of a frame -> OVERRUN pulse, original byte still received correctly.
REQ-035 RST_N low at bit 5 -> no DATA_VALID, outputs 0; next full frame of 8'h3C received correctly.
REQ-036 Macro on, 300 erroneous frames with ERR_CNT_W=8 -> ERR_CNT=255; macro off -> ERR_CNT=0.
